// File: rtl/mux_16to1.sv
// mux_16to1: registered 16-to-1 lane selector.
//
// Picks one of sixteen WIDTH-bit lanes from the packed input vector by a
// 4-bit select and presents it on a flopped output one clock later. Both
// outputs come straight from flops, so there is no input-to-output
// combinational path.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset (priority over in_valid)
//   i         packed lanes, lane k at bits [k*WIDTH +: WIDTH] (lane 0 = LSBs)
//   s         lane select, 0..15 (every value legal)
//   in_valid  qualifies i/s for capture this cycle
//   f         selected lane, registered; holds when in_valid is low
//   out_valid high for the one cycle after an accepted in_valid
module mux_16to1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16*WIDTH-1:0]   i,
  input  logic [3:0]            s,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      f,
  output logic                  out_valid
);

  logic [WIDTH-1:0] lane_sel;
  logic [WIDTH-1:0] f_d, f_q;
  logic             out_valid_d, out_valid_q;

  // Decode the select as a compare per lane; all 16 codes map to a lane.
  always_comb begin
    lane_sel = '0;
    for (int k = 0; k < 16; k++) begin
      if (s == 4'(k)) begin
        lane_sel = i[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    f_d         = f_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      f_d = lane_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      f_q         <= f_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign f         = f_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_16to1.sv
// Testbench for mux_16to1: a WIDTH=1 instance checked against a vector table
// and a WIDTH=8 instance checked against a shift-based reference model, plus
// hand-written sequences and randomized traffic with occasional resets.
module tb_mux_16to1;

  logic         clk;
  logic         rst;
  logic [15:0]  i1;
  logic [127:0] i8;
  logic [3:0]   s;
  logic         in_valid;
  logic [0:0]   f1;
  logic [7:0]   f8;
  logic         ov1, ov8;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [0:0] m_f1;
  logic [7:0] m_f8;
  logic       m_v;

  mux_16to1 #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .i         (i1),
    .s         (s),
    .in_valid  (in_valid),
    .f         (f1),
    .out_valid (ov1)
  );

  mux_16to1 #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .i         (i8),
    .s         (s),
    .in_valid  (in_valid),
    .f         (f8),
    .out_valid (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [15:0] i;
    logic [3:0]  s;
    logic        exp_f;
    logic        exp_v;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [0:0] ref_lane1(logic [15:0] v, logic [3:0] sel);
    return 1'((v >> sel) & 16'h1);
  endfunction

  function automatic logic [7:0] ref_lane8(logic [127:0] v, logic [3:0] sel);
    return 8'(v >> (32'(sel) * 8));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance the model with the currently driven inputs, then take one edge.
  task automatic tick();
    if (rst) begin
      m_f1 = '0;
      m_f8 = '0;
      m_v  = 1'b0;
    end else begin
      m_v = in_valid;
      if (in_valid) begin
        m_f1 = ref_lane1(i1, s);
        m_f8 = ref_lane8(i8, s);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    check({tag, "_f1"}, 32'(f1), 32'(m_f1));
    check({tag, "_v1"}, 32'(ov1), 32'(m_v));
    check({tag, "_f8"}, 32'(f8), 32'(m_f8));
    check({tag, "_v8"}, 32'(ov8), 32'(m_v));
  endtask

  function automatic logic [127:0] lanes_10k();
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(8'h10 + k);
    return r;
  endfunction

  initial begin
    vec_t r;
    rst = 1'b1; in_valid = 1'b0; i1 = '0; i8 = '0; s = '0;
    m_f1 = '0; m_f8 = '0; m_v = 1'b0;

    // Reset state
    tick();
    tick();
    check("reset_f1", 32'(f1), 32'h0);
    check("reset_v1", 32'(ov1), 32'h0);
    check("reset_f8", 32'(f8), 32'h0);
    check("reset_v8", 32'(ov8), 32'h0);

    // Walking one
    for (int k = 0; k < 16; k++) begin
      r = '{rst: 1'b0, v: 1'b1, i: 16'(1 << k), s: 4'(k), exp_f: 1'b1, exp_v: 1'b1};
      vecs.push_back(r);
    end
    // Mismatched select
    vecs.push_back('{rst: 1'b0, v: 1'b1, i: 16'h0001, s: 4'd1,  exp_f: 1'b0, exp_v: 1'b1});
    vecs.push_back('{rst: 1'b0, v: 1'b1, i: 16'h8000, s: 4'd14, exp_f: 1'b0, exp_v: 1'b1});
    vecs.push_back('{rst: 1'b0, v: 1'b1, i: 16'hFFFE, s: 4'd0,  exp_f: 1'b0, exp_v: 1'b1});
    vecs.push_back('{rst: 1'b0, v: 1'b1, i: 16'hFFFE, s: 4'd5,  exp_f: 1'b1, exp_v: 1'b1});
    // Hold
    vecs.push_back('{rst: 1'b0, v: 1'b1, i: 16'h0010, s: 4'd4,  exp_f: 1'b1, exp_v: 1'b1});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{rst: 1'b0, v: 1'b0, i: 16'h0000, s: 4'd0, exp_f: 1'b1, exp_v: 1'b0});
    // Reset priority, then the same capture without reset
    vecs.push_back('{rst: 1'b1, v: 1'b1, i: 16'hFFFF, s: 4'd7,  exp_f: 1'b0, exp_v: 1'b0});
    vecs.push_back('{rst: 1'b0, v: 1'b1, i: 16'hFFFF, s: 4'd7,  exp_f: 1'b1, exp_v: 1'b1});

    i8 = lanes_10k();
    foreach (vecs[n]) begin
      rst = vecs[n].rst; in_valid = vecs[n].v; i1 = vecs[n].i; s = vecs[n].s;
      tick();
      check($sformatf("vec%0d_f", n), 32'(f1), 32'(vecs[n].exp_f));
      check($sformatf("vec%0d_v", n), 32'(ov1), 32'(vecs[n].exp_v));
      check($sformatf("vec%0d_f8", n), 32'(f8), 32'(m_f8));
    end

    // Wide lanes, back-to-back captures on consecutive cycles
    rst = 1'b0; in_valid = 1'b1; i8 = lanes_10k();
    s = 4'd0;  tick(); check("wide_s0",  32'(f8), 32'h10); check("wide_v0", 32'(ov8), 32'h1);
    s = 4'd9;  tick(); check("wide_s9",  32'(f8), 32'h19); check("wide_v9", 32'(ov8), 32'h1);
    s = 4'd15; tick(); check("wide_s15", 32'(f8), 32'h1F); check("wide_v15", 32'(ov8), 32'h1);
    in_valid = 1'b0; s = 4'd3; i8 = '0;
    tick(); check("wide_hold", 32'(f8), 32'h1F); check("wide_hold_v", 32'(ov8), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      rst      = ($urandom_range(0, 31) == 0);
      in_valid = 1'($urandom);
      s        = 4'($urandom);
      i1       = 16'($urandom);
      i8       = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_16to1.md
Name: mux_16to1

Overview:
- Registered 16-to-1 selector: picks one of sixteen WIDTH-bit input lanes by a 4-bit select and presents it on a registered output one clock later.
- Used wherever a datapath must steer one of 16 sources onto a shared bus with a clean, glitch-free registered output.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 1, bit width of each input lane and of the output (default 1 gives a 16-bit input vector and a 1-bit output).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- i  input  16*WIDTH  packed input lanes; lane k occupies bits [k*WIDTH +: WIDTH], so lane 0 is the LSBs
- s  input  4  lane select, unsigned 0..15
- in_valid  input  1  qualifies i/s for capture this cycle
- f  output  WIDTH  selected lane, registered
- out_valid  output  1  high for the one cycle after an accepted in_valid

Behaviour:
- Reset: on a rising clk with rst=1, f <= 0 and out_valid <= 0. Reset takes priority over in_valid.
- Capture: on a rising clk with rst=0 and in_valid=1:
  - f <= i[s*WIDTH +: WIDTH].
  - out_valid <= 1.
  - Latency is exactly one clock from the accepting edge.
- Hold: on a rising clk with rst=0 and in_valid=0, f holds its previous value and out_valid <= 0.
- Select decode: every 4-bit value of s is legal, so there is no out-of-range case.
  - s=0 selects bits [WIDTH-1:0].
  - s=15 selects bits [16*WIDTH-1:15*WIDTH].
- No combinational path from any input to f or out_valid; both outputs come straight from flops.
- Back-to-back: in_valid may stay high every cycle. Each cycle's i/s is captured independently (throughput 1 per clock, no backpressure).
- Changes on i or s while in_valid=0 have no effect on f.
- Reset mid-stream: a capture presented in the same cycle as rst=1 is discarded; f=0 and out_valid=0 after that edge.
- X-free: after reset the outputs never go unknown provided i and s are known when in_valid=1.

Test Plan:
1. Walking one, WIDTH=1: for k=0..15 drive i=(1<<k), s=k, in_valid=1 for one cycle. Required: f=1 and out_valid=1 on the cycle after each capture, all 16 lanes.
2. Mismatched select: i=16'h0001 with s=1, then i=16'h8000 with s=14. Required: f=0 both times. Then i=16'hFFFE with s=0 -> f=0, and with s=5 -> f=1.
3. Hold: capture i=16'h0010, s=4 (f=1), then drop in_valid and drive i=0, s=0 for 3 cycles. Required: f stays 1 and out_valid=0 throughout.
4. Reset priority: assert rst=1 together with in_valid=1, i=16'hFFFF, s=7. Required: after that edge f=0 and out_valid=0. Releasing rst and repeating the capture gives f=1.
5. Wide lanes, WIDTH=8: lane k = 8'h10+k. Select s=0, 9 and 15. Required: f=8'h10, 8'h19, 8'h1F respectively, each one cycle after capture. Also confirm back-to-back captures on consecutive cycles.
